logic_rs: RTL and testbench

LOGIC_RS -- requirements
Module: logic_rs

---
 rtl/logic_rs.sv | 227 ++++++++++++++++++++++
 tb/tb_logic_rs.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_rs.sv
// Reservation station feeding a single-cycle logic unit: entries snoop the CDB, dispatch
// round-robin into an EX register, and hold results in an output register until granted.
module logic_rs #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       issue_op,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [31:0]      lu_a,
  output logic [31:0]      lu_b,
  output logic [2:0]       lu_sel,
  input  logic [31:0]      lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data
);

  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  typedef logic [IdxW-1:0] idx_t;
  localparam idx_t LastIdx = idx_t'(NUM_ENTRIES - 1);

  // Entry storage
  logic [NUM_ENTRIES-1:0]            busy_q, busy_d;
  logic [NUM_ENTRIES-1:0][2:0]       op_q, op_d;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0] qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
  logic [NUM_ENTRIES-1:0][31:0]      vj_q, vj_d, vk_q, vk_d;
  idx_t                              rr_ptr_q, rr_ptr_d;

  // EX stage
  logic             ex_valid_q, ex_valid_d;
  logic [2:0]       ex_op_q, ex_op_d;
  logic [31:0]      ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [TAG_W-1:0] ex_dest_q, ex_dest_d;

  // Result register
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [31:0]      res_data_q, res_data_d;

  logic                   free_found;
  idx_t                   free_idx;
  logic [NUM_ENTRIES-1:0] ready_vec;
  logic                   disp_found;
  idx_t                   disp_idx;
  logic                   cdb_hit;
  logic                   ex_adv;
  logic                   ex_free;
  logic                   dispatch;
  logic                   issue_fire;
  logic                   byp_j, byp_k;

  assign cdb_hit    = cdb_valid && (cdb_tag != '0);
  assign ex_adv     = !res_valid_q || res_ready;
  assign ex_free    = !ex_valid_q || ex_adv;
  assign dispatch   = disp_found && ex_free;
  assign issue_ready = free_found;
  assign issue_fire = issue_valid && issue_ready && !flush;
  assign byp_j      = cdb_hit && (issue_qj == cdb_tag);
  assign byp_k      = cdb_hit && (issue_qk == cdb_tag);

  // Lowest-index free entry from registered busy bits only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  // Round-robin search starting at rr_ptr_q
  always_comb begin
    int unsigned c;
    idx_t        cand;
    c          = 0;
    cand       = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
      c = 32'(rr_ptr_q) + k;
      if (c >= NUM_ENTRIES) c = c - NUM_ENTRIES;
      cand = idx_t'(c);
      if (!disp_found && ready_vec[cand]) begin
        disp_found = 1'b1;
        disp_idx   = cand;
      end
    end
  end

  always_comb begin
    busy_d      = busy_q;
    op_d        = op_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    dest_d      = dest_q;
    rr_ptr_d    = rr_ptr_q;
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_dest_d   = ex_dest_q;
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;

    // Snoop keeps running under back-pressure
    if (cdb_hit) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (busy_q[i] && (qj_q[i] == cdb_tag)) begin
          qj_d[i] = '0;
          vj_d[i] = cdb_data;
        end
        if (busy_q[i] && (qk_q[i] == cdb_tag)) begin
          qk_d[i] = '0;
          vk_d[i] = cdb_data;
        end
      end
    end

    if (ex_adv) begin
      res_valid_d = ex_valid_q;
      if (ex_valid_q) begin
        res_tag_d  = ex_dest_q;
        res_data_d = lu_out;
      end
    end

    if (dispatch) begin
      busy_d[disp_idx] = 1'b0;
      rr_ptr_d   = (disp_idx == LastIdx) ? '0 : disp_idx + idx_t'(1);
      ex_valid_d = 1'b1;
      ex_op_d    = op_q[disp_idx];
      ex_a_d     = vj_q[disp_idx];
      ex_b_d     = vk_q[disp_idx];
      ex_dest_d  = dest_q[disp_idx];
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end

    // Issue targets a non-busy entry, so it never collides with snoop or dispatch
    if (issue_fire) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = issue_op;
      dest_d[free_idx] = issue_dest;
      qj_d[free_idx]   = byp_j ? '0 : issue_qj;
      vj_d[free_idx]   = byp_j ? cdb_data : issue_vj;
      qk_d[free_idx]   = byp_k ? '0 : issue_qk;
      vk_d[free_idx]   = byp_k ? cdb_data : issue_vk;
    end

    if (flush) begin
      busy_d      = '0;
      rr_ptr_d    = '0;
      ex_valid_d  = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      op_q        <= '0;
      qj_q        <= '0;
      qk_q        <= '0;
      vj_q        <= '0;
      vk_q        <= '0;
      dest_q      <= '0;
      rr_ptr_q    <= '0;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_dest_q   <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      op_q        <= op_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      dest_q      <= dest_d;
      rr_ptr_q    <= rr_ptr_d;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_dest_q   <= ex_dest_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  assign lu_a      = ex_valid_q ? ex_a_q : '0;
  assign lu_b      = ex_valid_q ? ex_b_q : '0;
  assign lu_sel    = ex_valid_q ? ex_op_q : '0;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_logic_rs.sv
// Bench for logic_rs: directed scenarios plus random traffic, with results matched by tag
// against an operand-resolution model and a behavioural logic unit.
module tb_logic_rs;

  logic        clk, rst_n, flush;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_op;
  logic [3:0]  issue_qj, issue_qk, issue_dest;
  logic [31:0] issue_vj, issue_vk;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [31:0] lu_a, lu_b, lu_out;
  logic [2:0]  lu_sel;
  logic        res_valid, res_ready;
  logic [3:0]  res_tag;
  logic [31:0] res_data;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  qj, qk, dest;
    logic [31:0] vj, vk;
  } ins_t;
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  ins_t       pend_q[$];
  exp_t       exp_q[$];
  logic [3:0] got_tags[$];
  int         checks = 0;
  int         errors = 0;

  logic_rs #(.NUM_ENTRIES(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_dest(issue_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_out(lu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data)
  );

  function automatic logic [31:0] lu_f(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~(a & b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return 32'd0 - a;
    endcase
  endfunction

  assign lu_out = lu_f(lu_sel, lu_a, lu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Resolve operands against the broadcast, then retire fully known ops to the scoreboard
  function automatic void model_resolve();
    ins_t keep[$];
    ins_t x;
    exp_t e;
    foreach (pend_q[i]) begin
      x = pend_q[i];
      if (cdb_valid && cdb_tag != 4'd0) begin
        if (x.qj == cdb_tag) begin x.qj = 4'd0; x.vj = cdb_data; end
        if (x.qk == cdb_tag) begin x.qk = 4'd0; x.vk = cdb_data; end
      end
      if (x.qj == 4'd0 && x.qk == 4'd0) begin
        e.tag  = x.dest;
        e.data = lu_f(x.op, x.vj, x.vk);
        exp_q.push_back(e);
      end else begin
        keep.push_back(x);
      end
    end
    pend_q = keep;
  endfunction

  task automatic tick();
    ins_t x;
    if (flush) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (issue_valid && issue_ready) begin
        x.op = issue_op; x.qj = issue_qj; x.qk = issue_qk;
        x.vj = issue_vj; x.vk = issue_vk; x.dest = issue_dest;
        pend_q.push_back(x);
      end
      model_resolve();
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_issue(input logic [2:0] op, input logic [3:0] qj, input logic [3:0] qk,
                           input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest);
    issue_valid = 1'b1; issue_op = op; issue_qj = qj; issue_qk = qk;
    issue_vj = vj; issue_vk = vk; issue_dest = dest;
  endtask

  task automatic drain(input string name, input bit bcast, input int max_cyc);
    int n;
    n = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < max_cyc) begin
      if (bcast) begin
        cdb_valid = 1'b1;
        cdb_tag   = 4'(8 + (n % 8));
        cdb_data  = $urandom;
      end
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d results and %0d waiting ops outstanding, want 0",
               name, exp_q.size(), pend_q.size());
    end
  endtask

  function automatic bit tag_in_use(input logic [3:0] t);
    foreach (pend_q[i]) if (pend_q[i].dest == t) return 1'b1;
    foreach (exp_q[i]) if (exp_q[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every granted result must match an outstanding expectation by tag
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) if (idx < 0 && exp_q[i].tag == res_tag) idx = i;
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL result_tag: got unexpected tag %0d data %h, want no result", res_tag,
                 res_data);
      end else begin
        if (exp_q[idx].data !== res_data) begin
          errors++;
          $display("FAIL result_data tag %0d: got %h want %h", res_tag, res_data,
                   exp_q[idx].data);
        end
        exp_q.delete(idx);
      end
      got_tags.push_back(res_tag);
    end
  end

  task automatic basic_ready_issue(input string name);
    res_ready = 1'b1;
    set_issue(3'd0, 4'd0, 4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3);
    tick();
    tick();
    chk({name, "_ex_lu_a"}, lu_a, 32'hF0F0F0F0);
    chk({name, "_res_valid_early"}, {31'd0, res_valid}, 32'd0);
    tick();
    chk({name, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({name, "_res_tag"}, {28'd0, res_tag}, 32'd3);
    chk({name, "_res_data"}, res_data, 32'hF000F000);
    drain(name, 1'b0, 10);
  endtask

  initial begin
    logic [3:0] order_want[6];
    int         cyc;
    logic [3:0] d;
    issue_valid = 0; issue_op = 0; issue_qj = 0; issue_qk = 0; issue_vj = 0; issue_vk = 0;
    issue_dest = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; res_ready = 0; flush = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_lu_a", lu_a, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    basic_ready_issue("ready_issue");

    // Operand a waits for tag 5
    set_issue(3'd4, 4'd5, 4'd0, 32'd0, 32'h0000FFFF, 4'd2);
    tick();
    tick();
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h12345678;
    tick();
    tick();
    chk("cdb_wait_dispatch_lu_a", lu_a, 32'h12345678);
    chk("cdb_wait_dispatch_sel", {29'd0, lu_sel}, 32'd4);
    drain("cdb_wait", 1'b0, 10);

    // Both operands bypassed from a same-cycle broadcast
    set_issue(3'd7, 4'd7, 4'd7, 32'd0, 32'd0, 4'd4);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h0000000F;
    tick();
    drain("bypass", 1'b0, 10);

    // Fill four entries, EX and the result register under back-pressure
    res_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      set_issue(3'(i), 4'd0, 4'd0, $urandom, $urandom, 4'(i));
      tick();
    end
    chk("full_issue_ready", {31'd0, issue_ready}, 32'd0);
    set_issue(3'd1, 4'd0, 4'd0, 32'h1, 32'h2, 4'd7);
    tick();
    chk("full_ignored_issue_ready", {31'd0, issue_ready}, 32'd0);
    got_tags.delete();
    res_ready = 1'b1;
    repeat (6) tick();
    chk("full_throughput_count", got_tags.size(), 32'd6);
    order_want = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4};
    for (int i = 0; i < 6; i++) begin
      if (i < got_tags.size()) chk($sformatf("rr_order_%0d", i), {28'd0, got_tags[i]},
                                   {28'd0, order_want[i]});
    end
    drain("full", 1'b0, 10);

    // Flush with three waiting entries and a held result, plus an overridden issue
    res_ready = 1'b0;
    set_issue(3'd0, 4'd0, 4'd0, 32'hAAAA5555, 32'hFFFFFFFF, 4'd1);
    tick();
    for (int i = 2; i <= 4; i++) begin
      set_issue(3'd1, 4'd9, 4'd0, 32'd0, 32'd1, 4'(i));
      tick();
    end
    chk("flush_pre_res_valid", {31'd0, res_valid}, 32'd1);
    flush = 1'b1;
    set_issue(3'd0, 4'd0, 4'd0, 32'd1, 32'd1, 4'd5);
    tick();
    chk("flush_res_valid", {31'd0, res_valid}, 32'd0);
    chk("flush_issue_ready", {31'd0, issue_ready}, 32'd1);
    res_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h5;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("flush_quiet_%0d", i), {31'd0, res_valid}, 32'd0);
    end

    // Asynchronous reset while results are pending
    res_ready = 1'b0;
    set_issue(3'd1, 4'd0, 4'd0, 32'h1, 32'h2, 4'd1);
    tick();
    set_issue(3'd2, 4'd0, 4'd0, 32'h3, 32'h4, 4'd2);
    tick();
    tick();
    chk("areset_pre_res_valid", {31'd0, res_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("areset_res_tag", {28'd0, res_tag}, 32'd0);
    chk("areset_res_data", res_data, 32'd0);
    chk("areset_lu_a", lu_a, 32'd0);
    chk("areset_lu_b", lu_b, 32'd0);
    chk("areset_lu_sel", {29'd0, lu_sel}, 32'd0);
    chk("areset_issue_ready", {31'd0, issue_ready}, 32'd1);
    pend_q.delete();
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    basic_ready_issue("post_reset");

    // Random traffic
    for (cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = 4'($urandom_range(1, 15));
        while (tag_in_use(d)) d = 4'($urandom_range(1, 15));
        set_issue(3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 15)) : 4'd0,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 15)) : 4'd0,
                  $urandom, $urandom, d);
      end
      if ($urandom_range(0, 2) == 0) begin
        cdb_valid = 1'b1;
        cdb_tag   = 4'($urandom_range(0, 15));
        cdb_data  = $urandom;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("random", 1'b1, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
